regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (RegisterDestination/WriteData/WriteEnable) between two sources:
//   - the in-order pipeline writeback stage (WB);
//   - a long-latency unit (MD, mul/div or late loads) whose results arrive out of band.
//  MD results queue in a small FIFO. WB has priority. An age counter forces an MD write when MD has waited too

---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the WB stage, the MD unit and the register file write port.
// Carries the WB request/stall, the MD valid/ready push and the granted rf_* write.
interface regfile_write_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [31:0] md_pending;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    modport master (
        output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data,
        input  wb_stall, md_ready, md_pending, rf_we, rf_rd, rf_wd
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data,
        output wb_stall, md_ready, md_pending, rf_we, rf_rd, rf_wd
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between WB (priority) and a queued MD result stream.
// Latency: WB writes pass through combinationally; an MD result is writable one cycle after its push.
// Backpressure: md_ready drops while the MD FIFO is full; wb_stall holds WB for one forced MD write.
module regfile_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_e;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    state_e        state_q, state_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] age_q, age_d;
    logic [31:0]   pending_q, pending_d;

    entry_t      head;
    logic        wb_wr, md_rdy, push, pop, grant, md_wr, force_wr;
    logic        rf_we_c;
    logic [4:0]  rf_rd_c;
    logic [31:0] rf_wd_c;

    always_comb begin
        head     = fifo_q[rd_ptr_q];
        wb_wr    = bus.wb_we && (bus.wb_rd != 5'd0);
        md_rdy   = count_q < CW'(DEPTH);
        push     = bus.md_valid && md_rdy && (bus.md_rd != 5'd0);
        grant    = 1'b0;
        pop      = 1'b0;
        md_wr    = 1'b0;
        force_wr = 1'b0;
        age_d    = age_q;

        case (state_q)
            IDLE: grant = wb_wr;
            default: begin
                // A cancelled head is discarded without using the port, so WB keeps it.
                if (!head.live) begin
                    pop   = 1'b1;
                    grant = wb_wr;
                    age_d = '0;
                end else if (state_q == FORCE) begin
                    force_wr = 1'b1;
                    md_wr    = 1'b1;
                    pop      = 1'b1;
                    age_d    = '0;
                end else if (wb_wr) begin
                    grant = 1'b1;
                    if (age_q != AW'(MAX_WAIT)) age_d = age_q + AW'(1);
                end else begin
                    md_wr = 1'b1;
                    pop   = 1'b1;
                    age_d = '0;
                end
            end
        endcase

        rf_we_c = grant || md_wr;
        rf_rd_c = md_wr ? head.rd   : (grant ? bus.wb_rd   : 5'd0);
        rf_wd_c = md_wr ? head.data : (grant ? bus.wb_data : 32'd0);

        // A granted WB write is younger than every queued result to the same rd.
        for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
            if (grant && (fifo_q[i].rd == bus.wb_rd)) fifo_d[i].live = 1'b0;
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            fifo_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = '{live: 1'b1, rd: bus.md_rd, data: bus.md_data};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_d[i].live) pending_d[fifo_d[i].rd] = 1'b1;
        end

        if (count_d == '0)                 state_d = IDLE;
        else if (age_d == AW'(MAX_WAIT))   state_d = FORCE;
        else                               state_d = DRAIN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            age_q     <= '0;
            pending_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            pending_q <= pending_d;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    assign bus.rf_we      = rst && rf_we_c;
    assign bus.rf_rd      = rst ? rf_rd_c : 5'd0;
    assign bus.rf_wd      = rst ? rf_wd_c : 32'd0;
    assign bus.wb_stall   = rst && force_wr;
    assign bus.md_ready   = rst && md_rdy;
    assign bus.md_pending = rst ? pending_q : 32'd0;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, hand-built starvation/full/reset sequences,
// and random traffic, all compared against a queue-based reference of the arbitration rules.
module tb_regfile_write_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: queue of outstanding MD results in arrival order, plus how long the head has waited.
    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;
    ment_t q[$];
    int    m_age = 0;

    logic        m_we, m_stall, m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_wd, m_pend;
    logic        a_we, a_stall, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_wd, a_pend;

    function automatic void model_step();
        logic wbw, grant, pop, ready;
        m_we = 0; m_stall = 0; m_ready = 0; m_rd = 0; m_wd = 0; m_pend = 0;
        if (!rst) begin
            q.delete();
            m_age = 0;
            return;
        end
        ready   = (q.size() < DEPTH);
        m_ready = ready;
        foreach (q[i]) if (q[i].live) m_pend[q[i].rd] = 1'b1;
        wbw   = bus.wb_we && (bus.wb_rd != 0);
        grant = 0;
        pop   = 0;
        if (q.size() == 0) begin
            grant = wbw;
        end else if (!q[0].live) begin
            pop = 1; grant = wbw; m_age = 0;
        end else if (m_age == MAX_WAIT) begin
            m_stall = 1; m_we = 1; m_rd = q[0].rd; m_wd = q[0].data; pop = 1; m_age = 0;
        end else if (wbw) begin
            grant = 1;
            if (m_age < MAX_WAIT) m_age++;
        end else begin
            m_we = 1; m_rd = q[0].rd; m_wd = q[0].data; pop = 1; m_age = 0;
        end
        if (grant) begin
            m_we = 1; m_rd = bus.wb_rd; m_wd = bus.wb_data;
            foreach (q[i]) if (q[i].rd == bus.wb_rd) q[i].live = 1'b0;
        end
        if (pop) void'(q.pop_front());
        if (bus.md_valid && ready && (bus.md_rd != 0))
            q.push_back('{live: 1'b1, rd: bus.md_rd, data: bus.md_data});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                          input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wd;
        bus.md_valid = mv; bus.md_rd = mrd; bus.md_data = md;
    endtask

    // Sample at the falling edge, advance the reference, then let the rising edge commit.
    task automatic step();
        @(negedge clk);
        a_we = bus.rf_we; a_rd = bus.rf_rd; a_wd = bus.rf_wd;
        a_stall = bus.wb_stall; a_ready = bus.md_ready; a_pend = bus.md_pending;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_rf_we"},      a_we,    m_we);
        check({tag, "_wb_stall"},   a_stall, m_stall);
        check({tag, "_md_ready"},   a_ready, m_ready);
        check({tag, "_md_pending"}, a_pend,  m_pend);
        if (m_we) begin
            check({tag, "_rf_rd"}, a_rd, m_rd);
            check({tag, "_rf_wd"}, a_wd, m_wd);
        end
    endtask

    typedef struct {
        logic        rst, wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        md_valid;
        logic [4:0]  md_rd;
        logic [31:0] md_data;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_stall, e_ready;
        logic [31:0] e_pend;
    } vec_t;
    vec_t tbl [15];

    initial begin
        //          rst we rd  wb_data       mv rd  md_data  | we rd wd            st rdy pend
        tbl[0]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0};
        tbl[1]  = '{1, 1, 5, 32'hA5A5A5A5, 0, 0, 32'h0,    1, 5, 32'hA5A5A5A5, 0, 1, 32'h0};
        tbl[2]  = '{1, 0, 0, 32'h0,        1, 3, 32'h11,   0, 0, 32'h0,        0, 1, 32'h0};
        tbl[3]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    1, 3, 32'h11,       0, 1, 32'h8};
        tbl[4]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 32'h0};
        tbl[5]  = '{1, 0, 0, 32'h0,        1, 4, 32'h22,   0, 0, 32'h0,        0, 1, 32'h0};
        tbl[6]  = '{1, 1, 4, 32'h33,       0, 0, 32'h0,    1, 4, 32'h33,       0, 1, 32'h10};
        tbl[7]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 32'h0};
        tbl[8]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 32'h0};
        tbl[9]  = '{1, 0, 0, 32'h0,        1, 0, 32'h99,   0, 0, 32'h0,        0, 1, 32'h0};
        tbl[10] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 32'h0};
        tbl[11] = '{1, 1, 0, 32'h77,       0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 32'h0};
        tbl[12] = '{1, 1, 6, 32'h66,       1, 6, 32'h55,   1, 6, 32'h66,       0, 1, 32'h0};
        tbl[13] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    1, 6, 32'h55,       0, 1, 32'h40};
        tbl[14] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 32'h0,        0, 1, 32'h0};

        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            rst = tbl[i].rst;
            set_in(tbl[i].wb_we, tbl[i].wb_rd, tbl[i].wb_data, tbl[i].md_valid, tbl[i].md_rd, tbl[i].md_data);
            step();
            cmp_model(t);
            check({t, "_vec_we"},    a_we,    tbl[i].e_we);
            check({t, "_vec_stall"}, a_stall, tbl[i].e_stall);
            check({t, "_vec_ready"}, a_ready, tbl[i].e_ready);
            check({t, "_vec_pend"},  a_pend,  tbl[i].e_pend);
            if (tbl[i].e_we) begin
                check({t, "_vec_rd"}, a_rd, tbl[i].e_rd);
                check({t, "_vec_wd"}, a_wd, tbl[i].e_wd);
            end
        end

        // Starvation: WB hogs the port until the head has waited MAX_WAIT cycles.
        set_in(0, 0, 0, 1, 7, 32'h77);
        step();
        cmp_model("t3_push");
        for (int c = 1; c <= 20; c++) begin
            set_in(1, 9, 32'h900 + c, 0, 0, 0);
            step();
            cmp_model("t3");
            if (c == MAX_WAIT + 1) begin
                check("t3_force_stall", a_stall, 1);
                check("t3_force_rd",    a_rd,    7);
                check("t3_force_wd",    a_wd,    32'h77);
            end else begin
                check("t3_wb_stall", a_stall, 0);
                check("t3_wb_rd",    a_rd,    9);
                check("t3_wb_wd",    a_wd,    32'h900 + c);
            end
        end

        // Fill the FIFO behind continuous WB traffic, then watch the forced pop free a slot.
        for (int c = 0; c < 4; c++) begin
            set_in(1, 9, c, 1, 5'(10 + c), 32'hB0 + c);
            step();
            cmp_model("t5_fill");
            check("t5_ready_fill", a_ready, 1);
        end
        for (int c = 4; c <= 10; c++) begin
            set_in(1, 9, c, 0, 0, 0);
            step();
            cmp_model("t5_hold");
            if (c == 4) check("t5_full_ready", a_ready, 0);
            if (c == MAX_WAIT + 1) begin
                check("t5_force_stall", a_stall, 1);
                check("t5_force_rd",    a_rd,    10);
            end
            if (c == MAX_WAIT + 2) check("t5_ready_after_pop", a_ready, 1);
        end
        for (int c = 0; c < 4; c++) begin
            set_in(0, 0, 0, 0, 0, 0);
            step();
            cmp_model("t5_drain");
            if (c < 3) check("t5_drain_rd", a_rd, 5'(11 + c));
        end

        // Reset while three results are still queued.
        for (int c = 0; c < 3; c++) begin
            set_in(1, 20, c, 1, 5'(1 + c), 32'hC0 + c);
            step();
            cmp_model("t6_fill");
        end
        set_in(1, 20, 3, 0, 0, 0);
        step();
        cmp_model("t6_pre");
        check("t6_pend_pre", a_pend, 32'hE);
        rst = 1'b0;
        set_in(1, 20, 4, 1, 5, 32'hC5);
        step();
        cmp_model("t6_rst");
        check("t6_rst_we",    a_we,    0);
        check("t6_rst_pend",  a_pend,  0);
        check("t6_rst_ready", a_ready, 0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 0, 0, 0, 0);
            step();
            cmp_model("t6_post");
            check("t6_post_we",    a_we,    0);
            check("t6_post_ready", a_ready, 1);
            check("t6_post_pend",  a_pend,  0);
        end

        // Random traffic with a narrow rd range so WAW cancels and collisions are common.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) != 0);
            set_in(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom);
            step();
            cmp_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
